// File: rtl/sm4_round_ctrl.sv
// SM4 block cipher round controller: round-key file, IDLE/RUN/DONE handshake FSM and
// a single-round-per-clock datapath over a 128-bit working state.
module sm4_round_ctrl #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_we,
  input  logic [4:0]   key_addr,
  input  logic [31:0]  key_wdata,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_decrypt,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [4:0] LastCnt = 5'(ROUNDS - 1);

  // Listed in natural order, so entry 0 lands at the top index; look up with ~x.
  localparam logic [255:0][7:0] SboxTable = {
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2,
    8'h28, 8'hfb, 8'h2c, 8'h05, 8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
    8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99, 8'h9c, 8'h42, 8'h50, 8'hf4,
    8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa,
    8'h75, 8'h8f, 8'h3f, 8'ha6, 8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
    8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8, 8'h68, 8'h6b, 8'h81, 8'hb2,
    8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b,
    8'h01, 8'h21, 8'h78, 8'h87, 8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
    8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e, 8'hea, 8'hbf, 8'h8a, 8'hd2,
    8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30,
    8'hf5, 8'h8c, 8'hb1, 8'he3, 8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
    8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f, 8'hd5, 8'hdb, 8'h37, 8'h45,
    8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41,
    8'h1f, 8'h10, 8'h5a, 8'hd8, 8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
    8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0, 8'h89, 8'h69, 8'h97, 8'h4a,
    8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e,
    8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [127:0]   blk_q, blk_d;
  logic           dec_q, dec_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [31:0]    rk_q [32];

  logic [31:0]    x0, x1, x2, x3;
  logic [4:0]     rk_idx;
  logic [31:0]    rk_sel;
  logic [127:0]   round_out;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTable[~x];
  endfunction

  // Round transform T: byte-wise S-box followed by the linear diffusion L.
  function automatic logic [31:0] t_round(input logic [31:0] a);
    logic [31:0] b;
    b = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]}
             ^ {b[7:0], b[31:8]};
  endfunction

  assign x0 = blk_q[127:96];
  assign x1 = blk_q[95:64];
  assign x2 = blk_q[63:32];
  assign x3 = blk_q[31:0];

  assign rk_idx    = dec_q ? (LastCnt - cnt_q) : cnt_q;
  assign rk_sel    = rk_q[rk_idx];
  assign round_out = {x1, x2, x3, x0 ^ t_round(x1 ^ x2 ^ x3 ^ rk_sel)};

  // Keys are deliberately outside the reset domain so they survive a reset.
  always_ff @(posedge clk) begin
    if (!rst && key_we && (state_q == StIdle)) begin
      rk_q[key_addr] <= key_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (in_valid) begin
          blk_d   = in_data;
          dec_d   = in_decrypt;
          state_d = StRun;
        end
      end
      StRun: begin
        blk_d = round_out;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDone: begin
        cnt_d = '0;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      blk_q   <= '0;
      dec_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_valid ? {x3, x2, x1, x0} : '0;

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Self-checking bench for sm4_round_ctrl: transaction-level SM4 reference model,
// per-cycle output comparison, directed golden-vector scenarios and random traffic.
module tb_sm4_round_ctrl;

  localparam int unsigned ROUNDS = 32;
  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [255:0][7:0] SboxT = {
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2,
    8'h28, 8'hfb, 8'h2c, 8'h05, 8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
    8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99, 8'h9c, 8'h42, 8'h50, 8'hf4,
    8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa,
    8'h75, 8'h8f, 8'h3f, 8'ha6, 8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
    8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8, 8'h68, 8'h6b, 8'h81, 8'hb2,
    8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b,
    8'h01, 8'h21, 8'h78, 8'h87, 8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
    8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e, 8'hea, 8'hbf, 8'h8a, 8'hd2,
    8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30,
    8'hf5, 8'h8c, 8'hb1, 8'he3, 8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
    8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f, 8'hd5, 8'hdb, 8'h37, 8'h45,
    8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41,
    8'h1f, 8'h10, 8'h5a, 8'hd8, 8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
    8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0, 8'h89, 8'h69, 8'h97, 8'h4a,
    8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e,
    8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic         clk;
  logic         rst;
  logic         key_we;
  logic [4:0]   key_addr;
  logic [31:0]  key_wdata;
  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  sm4_round_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_wdata (key_wdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_decrypt(in_decrypt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  logic [31:0] mk [32];
  logic [31:0] gold_rk [32];

  typedef enum {MIdle, MRun, MDone} mphase_e;
  mphase_e      m_phase = MIdle;
  int           m_left  = 0;
  logic [127:0] m_res   = '0;
  int           acc_log [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) b[8*i +: 8] = SboxT[255 - int'(a[8*i +: 8])];
    return b;
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  // Textbook SM4: X[i+4] = X[i] ^ T(X[i+1]^X[i+2]^X[i+3]^rk), output reversed.
  function automatic logic [127:0] sm4_model(input logic [127:0] blk, input logic dec);
    logic [31:0] x [36];
    logic [31:0] k;
    for (int i = 0; i < 4; i++) x[i] = blk[127 - 32*i -: 32];
    for (int r = 0; r < 32; r++) begin
      k = dec ? mk[31 - r] : mk[r];
      x[r + 4] = x[r] ^ t_enc(x[r + 1] ^ x[r + 2] ^ x[r + 3] ^ k);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] fk [4];
    logic [31:0] kk [36];
    logic [31:0] ck;
    fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
    for (int i = 0; i < 4; i++) kk[i] = key[127 - 32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      kk[i + 4] = kk[i] ^ t_key(kk[i + 1] ^ kk[i + 2] ^ kk[i + 3] ^ ck);
      gold_rk[i] = kk[i + 4];
    end
  endtask

  // Transaction-level model of the controller, advanced on each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_phase = MIdle;
      m_left  = 0;
      m_res   = '0;
    end else begin
      case (m_phase)
        MIdle: begin
          if (key_we) mk[key_addr] = key_wdata;
          if (in_valid) begin
            m_res   = sm4_model(in_data, in_decrypt);
            m_left  = ROUNDS;
            m_phase = MRun;
            acc_log.push_back(cyc);
          end
        end
        MRun: begin
          m_left--;
          if (m_left == 0) m_phase = MDone;
        end
        MDone: if (out_ready) m_phase = MIdle;
        default: m_phase = MIdle;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("cyc_in_ready", 128'(in_ready), 128'(m_phase == MIdle));
      chk("cyc_out_valid", 128'(out_valid), 128'(m_phase == MDone));
      chk("cyc_busy", 128'(busy), 128'(m_phase != MIdle));
      if (m_phase == MDone) chk("cyc_out_data", out_data, m_res);
    end
  end

  task automatic send(input logic [127:0] d, input logic dec, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 128'(in_ready), 128'd1);
    in_valid   = 1'b1;
    in_data    = d;
    in_decrypt = dec;
    @(posedge clk);
    #1;
    acc = cyc;
    @(negedge clk);
    in_valid   = 1'b0;
    in_data    = {$urandom, $urandom, $urandom, $urandom};
    in_decrypt = ~dec;
  endtask

  task automatic wait_valid(output int t);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("valid_timeout", 128'(out_valid), 128'd1);
    t = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, t, n;
    bit seen;
    rst = 1'b1; key_we = 1'b0; key_addr = '0; key_wdata = '0;
    in_valid = 1'b0; in_decrypt = 1'b0; in_data = '0; out_ready = 1'b0;

    expand_key(PT);
    chk("gold_rk0", 128'(gold_rk[0]), 128'(32'hf12186f9));
    chk("gold_rk31", 128'(gold_rk[31]), 128'(32'h9124a012));

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_data", out_data, 128'd0);

    for (int i = 0; i < 32; i++) begin
      key_we = 1'b1; key_addr = 5'(i); key_wdata = gold_rk[i];
      @(negedge clk);
    end
    key_we = 1'b0;
    chk("model_enc", sm4_model(PT, 1'b0), CT);
    chk("model_dec", sm4_model(CT, 1'b1), PT);

    // Golden encrypt, then backpressure hold.
    send(PT, 1'b0, acc);
    wait_valid(t);
    chk("enc_latency", 128'(t - acc), 128'd32);
    chk("enc_data", out_data, CT);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_data", out_data, CT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", 128'(in_ready), 128'd1);
    chk("bp_release_valid", 128'(out_valid), 128'd0);

    // Golden decrypt with out_ready held high from the start.
    send(CT, 1'b1, acc);
    wait_valid(t);
    chk("dec_latency", 128'(t - acc), 128'd32);
    chk("dec_data", out_data, PT);

    // Key write while busy must be ignored.
    send(PT, 1'b0, acc);
    repeat (5) @(negedge clk);
    key_we = 1'b1; key_addr = 5'd5; key_wdata = $urandom;
    repeat (3) @(negedge clk);
    key_we = 1'b0;
    wait_valid(t);
    chk("busy_wr_data", out_data, CT);
    send(PT, 1'b0, acc);
    wait_valid(t);
    chk("rk5_kept_data", out_data, CT);

    // Reset at round 17, then accept on the first edge after release.
    send(PT, 1'b0, acc);
    repeat (17) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    chk("accept_after_rst", 128'(busy), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(t);
    chk("abort_latency", 128'(t - acc), 128'd32);
    chk("abort_next_data", out_data, CT);

    // Back-to-back with in_valid held.
    @(negedge clk);
    acc_log.delete();
    in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0;
    n = 0;
    while (acc_log.size() < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("b2b_count", 128'(acc_log.size() >= 3), 128'd1);
    for (int i = 1; i < acc_log.size() && i < 3; i++)
      chk("b2b_gap", 128'(acc_log[i] - acc_log[i - 1]), 128'd34);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid && out_data !== CT) seen = 1'b1;
    end
    chk("b2b_data_ok", 128'(seen), 128'd0);

    // Random traffic: modes, data, backpressure, key writes and occasional reset.
    repeat (3000) begin
      @(negedge clk);
      in_valid   = ($urandom_range(2) == 0);
      in_data    = {$urandom, $urandom, $urandom, $urandom};
      in_decrypt = 1'($urandom_range(1));
      out_ready  = ($urandom_range(3) != 0);
      key_we     = ($urandom_range(5) == 0);
      key_addr   = 5'($urandom);
      key_wdata  = $urandom;
      rst        = ($urandom_range(399) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; key_we = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
